// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-core CPU fetch path.
package cpu_mc_pkg;

  localparam int NUM_CORES_DEF = 2;

  // Fetch arbiter FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above the last grant, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_any,
  output logic [IW-1:0] o_index
);

  logic w_found;
  int   w_cand;

  // Scan last+1, last+2, ... (mod N) and keep the first hit.
  always_comb begin
    o_any   = |i_req;
    o_index = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int i = 1; i <= N; i++) begin
      w_cand = (int'(i_last) + i) % N;
      if (!w_found && i_req[w_cand]) begin
        o_index = IW'(w_cand);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one instruction-memory port between NUM_CORES cores, round-robin,
// one outstanding access at a time, with per-core PC stall outputs.
//
// state | meaning
// IDLE  | no access in flight; arbitrate among requesting cores
// BUSY  | access issued to memory; wait for mem_ready_i
module imem_fetch_arbiter
  import cpu_mc_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CORES-1:0]        req_i,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_i,
  output logic                        mem_req_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  input  logic                        mem_ready_i,
  input  logic [DATA_W-1:0]           mem_data_i,
  output logic [DATA_W-1:0]           rdata_o,
  output logic [NUM_CORES-1:0]        valid_o,
  output logic [NUM_CORES-1:0]        stall_o
);

  localparam int GW = $clog2(NUM_CORES);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_CORES - 1);

  fetch_state_e           r_state;
  logic [GW-1:0]          r_grant;
  logic [GW-1:0]          r_last_grant;
  logic                   r_mem_req;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_rdata;
  logic [NUM_CORES-1:0]   r_valid;

  logic                   w_any;
  logic [GW-1:0]          w_pick;
  logic [ADDR_W-1:0]      w_pick_addr;

  rr_pick #(
    .N  (NUM_CORES),
    .IW (GW)
  ) u_rr_pick (
    .i_req   (req_i),
    .i_last  (r_last_grant),
    .o_any   (w_any),
    .o_index (w_pick)
  );

  assign w_pick_addr = addr_i[int'(w_pick)*ADDR_W +: ADDR_W];

  // Arbitration FSM; the picker only feeds the IDLE branch, never the ready path.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_INIT;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_rdata      <= '0;
      r_valid      <= '0;
    end else begin
      r_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant    <= w_pick;
            r_mem_addr <= w_pick_addr;
            r_mem_req  <= 1'b1;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready_i) begin
            r_rdata          <= mem_data_i;
            r_valid[r_grant] <= 1'b1;
            r_last_grant     <= r_grant;
            r_mem_req        <= 1'b0;
            r_state          <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;
  assign rdata_o    = r_rdata;
  assign valid_o    = r_valid;

  // A core's PC is released in the cycle its word arrives.
  assign stall_o = req_i & ~r_valid;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Scoreboard bench for imem_fetch_arbiter: stimulus pushes expected fetches,
// a negedge monitor compares whatever the DUT presents.
module tb_imem_fetch_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int              core;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        req;
  logic [N*AW-1:0]     addr;
  logic                mem_ready;
  logic [DW-1:0]       mem_data;
  logic                mem_req_o;
  logic [AW-1:0]       mem_addr_o;
  logic [DW-1:0]       rdata_o;
  logic [N-1:0]        valid_o;
  logic [N-1:0]        stall_o;

  exp_t                q[$];
  int                  last;
  logic [N-1:0]        exp_valid;
  bit                  exp_busy;
  int                  n_checks;
  int                  n_fail;

  imem_fetch_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req_i       (req),
    .addr_i      (addr),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ready_i (mem_ready),
    .mem_data_i  (mem_data),
    .rdata_o     (rdata_o),
    .valid_o     (valid_o),
    .stall_o     (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration rule: first requester scanning last+1 upward, mod N.
  function automatic int rr_next(input logic [N-1:0] r, input int lst);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (lst + i) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    exp_valid = '0;
  endtask

  task automatic raise_random();
    for (int k = 0; k < N; k++) begin
      if (!req[k] && $urandom_range(0, 2) == 0) begin
        req[k] = 1'b1;
        addr[k*AW +: AW] = $urandom & 32'hFFFF_FFFC;
      end
    end
  endtask

  // One arbitration slot starting in an IDLE cycle.
  task automatic arb_cycle(input int lat, input logic [DW-1:0] data, input bit drop, input bit rnd);
    int   w;
    exp_t e;
    mem_ready = 1'($urandom_range(0, 1));
    mem_data  = $urandom;
    w = rr_next(req, last);
    if (w >= 0) begin
      e.core = w;
      e.addr = addr[w*AW +: AW];
      e.data = data;
      q.push_back(e);
    end
    tick();
    if (w < 0) begin
      mem_ready = 1'b0;
      if (rnd) raise_random();
      return;
    end
    exp_busy = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      mem_ready = (i == lat);
      mem_data  = (i == lat) ? data : $urandom;
      if (drop && i == 1) req[w] = 1'b0;
      if (rnd && $urandom_range(0, 3) == 0) raise_random();
      tick();
    end
    mem_ready    = 1'b0;
    exp_busy     = 1'b0;
    exp_valid[w] = 1'b1;
    last         = w;
    if (rnd) begin
      if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
      else if (req[w]) addr[w*AW +: AW] = $urandom & 32'hFFFF_FFFC;
      raise_random();
    end else if (req[w]) begin
      addr[w*AW +: AW] = addr[w*AW +: AW] + 32'd4;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    exp_busy = 1'b0;
    q.delete();
    chk("rst_mem_req", 64'(mem_req_o), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    chk("rst_rdata", 64'(rdata_o), 64'(0));
    chk("rst_valid", 64'(valid_o), 64'(0));
    rst_n = 1'b1;
    last  = N - 1;
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 64'(valid_o), 64'(exp_valid));
      chk("stall", 64'(stall_o), 64'(req & ~exp_valid));
      chk("mem_req", 64'(mem_req_o), 64'(exp_busy));
      if (mem_req_o && q.size() > 0)
        chk("mem_addr", 64'(mem_addr_o), 64'(q[0].addr));
      if (valid_o != '0) begin
        if (q.size() == 0) begin
          chk("valid_unexpected", 64'(valid_o), 64'(0));
        end else begin
          chk("valid_core", 64'(valid_o), 64'(1) << q[0].core);
          chk("rdata", 64'(rdata_o), 64'(q[0].data));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_valid = '0;
    exp_busy  = 1'b0;
    req       = '0;
    addr      = '0;
    mem_data  = '0;
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    last      = N - 1;

    do_reset();

    // Single requester, single-cycle memory.
    addr[0 +: AW] = 32'h40;
    req = 2'b01;
    arb_cycle(1, 32'h1111_2222, 1'b0, 1'b0);
    req = 2'b00;
    tick();

    // Ready strobed while idle with nothing pending.
    mem_ready = 1'b1;
    mem_data  = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("idle_ready_mem_req", 64'(mem_req_o), 64'(0));

    // Both cores from reset: alternating grants.
    do_reset();
    addr[0 +: AW]  = 32'h100;
    addr[AW +: AW] = 32'h200;
    req = 2'b11;
    for (int t = 0; t < 4; t++) arb_cycle(1, $urandom, 1'b0, 1'b0);

    // Slow memory.
    req = 2'b01;
    arb_cycle(5, 32'h8C01_0004, 1'b0, 1'b0);
    req = 2'b00;
    tick();

    // Core 1 drops its request mid-access; core 0 is next.
    do_reset();
    req = 2'b11;
    arb_cycle(1, $urandom, 1'b0, 1'b0);
    arb_cycle(3, 32'hCAFE_0001, 1'b1, 1'b0);
    arb_cycle(2, 32'hCAFE_0002, 1'b0, 1'b0);

    // Reset while busy abandons the access; core 0 wins afterwards.
    req = 2'b11;
    begin
      exp_t e;
      int   w;
      w = rr_next(req, last);
      e.core = w;
      e.addr = addr[w*AW +: AW];
      e.data = '0;
      q.push_back(e);
      mem_ready = 1'b0;
      tick();
      exp_busy = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      exp_busy = 1'b0;
      q.delete();
      chk("rst_busy_mem_req", 64'(mem_req_o), 64'(0));
      chk("rst_busy_valid", 64'(valid_o), 64'(0));
      rst_n = 1'b1;
      last  = N - 1;
    end
    arb_cycle(1, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Randomized traffic.
    req = 2'($urandom_range(0, 3));
    for (int t = 0; t < 300; t++)
      arb_cycle($urandom_range(1, 6), $urandom, ($urandom_range(0, 4) == 0), 1'b1);

    req = '0;
    tick();
    tick();
    tick();
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
